// File: rtl/mac_pkg.sv
// Shared constants for the iterative multiply-accumulate unit: mode encodings,
// FSM state encoding and NZCV flag bit positions.
package mac_pkg;

  localparam logic [2:0] MODE_MUL   = 3'b000;
  localparam logic [2:0] MODE_MLA   = 3'b001;
  localparam logic [2:0] MODE_UMULL = 3'b100;
  localparam logic [2:0] MODE_UMLAL = 3'b101;
  localparam logic [2:0] MODE_SMULL = 3'b110;
  localparam logic [2:0] MODE_SMLAL = 3'b111;

  // Bit positions inside the mode field
  localparam int MODE_ACC  = 0;
  localparam int MODE_SGN  = 1;
  localparam int MODE_LONG = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/mac_iter_if.sv
// Request/response bundle between the writeback stage and the MAC unit.
interface mac_iter_if #(parameter int WIDTH = 32);
  import mac_pkg::*;

  logic             start;
  logic [2:0]       mode;
  logic             sat_en;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] acc_hi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       nzcv;

  modport master (
    output start, mode, sat_en, in1, in2, acc_lo, acc_hi,
    input  busy, done, result_lo, result_hi, nzcv
  );

  modport slave (
    input  start, mode, sat_en, in1, in2, acc_lo, acc_hi,
    output busy, done, result_lo, result_hi, nzcv
  );

endinterface

// File: rtl/mac_sat_flags.sv
// Final result formatting: optional signed clamp of short results and NZCV
// generation from the full 2*WIDTH accumulated sum.
module mac_sat_flags
  import mac_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] sum,
  input  logic               long_mode,
  input  logic               sat_en,
  output logic [WIDTH-1:0]   res_lo,
  output logic [WIDTH-1:0]   res_hi,
  output logic [3:0]         nzcv
);

  logic overflow;

  // The signed short sum fits in WIDTH bits iff its top WIDTH+1 bits all agree
  assign overflow = (|sum[2*WIDTH-1:WIDTH-1]) && !(&sum[2*WIDTH-1:WIDTH-1]);

  always_comb begin
    res_lo = sum[WIDTH-1:0];
    res_hi = '0;
    nzcv   = '0;
    if (long_mode) begin
      res_hi       = sum[2*WIDTH-1:WIDTH];
      nzcv[N_BIT]  = sum[2*WIDTH-1];
      nzcv[Z_BIT]  = (sum == '0);
    end else begin
      if (sat_en && overflow) begin
        res_lo      = sum[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        nzcv[V_BIT] = 1'b1;
      end
      nzcv[N_BIT] = res_lo[WIDTH-1];
      nzcv[Z_BIT] = (res_lo == '0);
    end
  end

endmodule

// File: rtl/mac_iter.sv
// Iterative multiply-accumulate: consumes BPC multiplier bits per CALC cycle,
// accumulating into a 2*WIDTH register, then formats results in FIN.
module mac_iter
  import mac_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 8
) (
  input logic       clk,
  input logic       reset,
  mac_iter_if.slave bus
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [PW-1:0]      prod_reg;
  logic [PW-1:0]      mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic               long_reg;
  logic               sat_reg;
  logic               sgn_reg;

  logic               last_step;
  logic               start_sgn;
  logic [PW-1:0]      acc_init;
  logic [PW-1:0]      mcand_init;
  logic [PW-1:0]      chunk_ext;
  logic [PW-1:0]      term;
  logic [WIDTH-1:0]   mplier_shift;
  logic [WIDTH-1:0]   fin_lo, fin_hi;
  logic [3:0]         fin_nzcv;

  assign last_step = (cnt_reg == CNT_W'(N - 1));

  // Short modes are only evaluated as signed when the clamp needs the true sign
  assign start_sgn  = bus.mode[MODE_LONG] ? bus.mode[MODE_SGN] : bus.sat_en;
  assign mcand_init = start_sgn ? {{WIDTH{bus.in1[WIDTH-1]}}, bus.in1}
                                : {{WIDTH{1'b0}}, bus.in1};

  always_comb begin
    acc_init = '0;
    if (bus.mode[MODE_ACC]) begin
      if (bus.mode[MODE_LONG]) acc_init = {bus.acc_hi, bus.acc_lo};
      else                     acc_init = {{WIDTH{bus.acc_lo[WIDTH-1]}}, bus.acc_lo};
    end
  end

  // The top chunk of a signed multiplier carries negative weight
  always_comb begin
    chunk_ext = {{(PW-BPC){1'b0}}, mplier_reg[BPC-1:0]};
    if (sgn_reg && last_step && mplier_reg[BPC-1]) chunk_ext[PW-1:BPC] = '1;
  end

  assign term = mcand_reg * chunk_ext;

  generate
    if (BPC < WIDTH) begin : g_shift
      assign mplier_shift = mplier_reg >> BPC;
    end else begin : g_noshift
      assign mplier_shift = '0;
    end
  endgenerate

  mac_sat_flags #(.WIDTH(WIDTH)) u_sat_flags (
    .sum       (prod_reg),
    .long_mode (long_reg),
    .sat_en    (sat_reg),
    .res_lo    (fin_lo),
    .res_hi    (fin_hi),
    .nzcv      (fin_nzcv)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_CALC;
      ST_CALC: if (last_step) state_next = ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg       <= '0;
      prod_reg      <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      long_reg      <= 1'b0;
      sat_reg       <= 1'b0;
      sgn_reg       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result_lo <= '0;
      bus.result_hi <= '0;
      bus.nzcv      <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            cnt_reg    <= '0;
            prod_reg   <= acc_init;
            mcand_reg  <= mcand_init;
            mplier_reg <= bus.in2;
            long_reg   <= bus.mode[MODE_LONG];
            sat_reg    <= bus.sat_en;
            sgn_reg    <= start_sgn;
            bus.busy   <= 1'b1;
          end
        end
        ST_CALC: begin
          prod_reg   <= prod_reg + term;
          mcand_reg  <= mcand_reg << BPC;
          mplier_reg <= mplier_shift;
          cnt_reg    <= cnt_reg + CNT_W'(1);
        end
        ST_FIN: begin
          bus.result_lo <= fin_lo;
          bus.result_hi <= fin_hi;
          bus.nzcv      <= fin_nzcv;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_iter.sv
// Randomised check of mac_iter at BPC = 4, 8 and 32 against an arithmetic
// reference model of the multiply-accumulate rules.
module tb_mac_iter;
  import mac_pkg::*;

  localparam int W  = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NI-1:0] start_v, done_v, busy_v;
  logic [2:0]    mode;
  logic          sat_en;
  logic [W-1:0]  in1, in2, acc_lo, acc_hi;
  logic [W-1:0]  rlo[NI];
  logic [W-1:0]  rhi[NI];
  logic [3:0]    nz[NI];

  int vectors     = 0;
  int miscompares = 0;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int BPC_I = (gi == 0) ? 4 : ((gi == 1) ? 8 : 32);
      mac_iter_if #(.WIDTH(W)) bus ();
      assign bus.start  = start_v[gi];
      assign bus.mode   = mode;
      assign bus.sat_en = sat_en;
      assign bus.in1    = in1;
      assign bus.in2    = in2;
      assign bus.acc_lo = acc_lo;
      assign bus.acc_hi = acc_hi;
      assign done_v[gi] = bus.done;
      assign busy_v[gi] = bus.busy;
      assign rlo[gi]    = bus.result_lo;
      assign rhi[gi]    = bus.result_hi;
      assign nz[gi]     = bus.nzcv;
      mac_iter #(.WIDTH(W), .BPC(BPC_I)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
      );
    end
  endgenerate

  function automatic int lat_of(input int i);
    int b;
    b = (i == 0) ? 4 : ((i == 1) ? 8 : 32);
    return W / b + 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Exact product-plus-accumulator in 64-bit arithmetic, then clamp/flags
  task automatic model(input logic [2:0] m, input logic s,
                       input logic [W-1:0] a, b, lo, hi,
                       output logic [W-1:0] elo, ehi, output logic [3:0] enz);
    logic   lng, sgn;
    longint ea, eb, eacc, p;
    lng = m[2];
    sgn = lng ? m[1] : s;
    if (sgn) begin
      ea = $signed(a);
      eb = $signed(b);
    end else begin
      ea = {32'b0, a};
      eb = {32'b0, b};
    end
    if (!m[0])    eacc = 0;
    else if (lng) eacc = {hi, lo};
    else          eacc = $signed(lo);
    p   = ea * eb + eacc;
    enz = 4'b0000;
    ehi = '0;
    if (lng) begin
      ehi    = p[63:32];
      elo    = p[31:0];
      enz[3] = p[63];
      enz[2] = (p == 0);
    end else begin
      elo = p[31:0];
      if (s && p > 64'sd2147483647) begin
        elo    = 32'h7FFF_FFFF;
        enz[0] = 1'b1;
      end else if (s && p < -64'sd2147483648) begin
        elo    = 32'h8000_0000;
        enz[0] = 1'b1;
      end
      enz[3] = elo[31];
      enz[2] = (elo == 0);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic scramble();
    mode   = 3'($urandom);
    sat_en = 1'($urandom);
    in1    = 32'($urandom);
    in2    = 32'($urandom);
    acc_lo = 32'($urandom);
    acc_hi = 32'($urandom);
  endtask

  // Start all three units together; inputs are scrambled after capture
  task automatic run_op(input string tag, input logic [2:0] m, input logic s,
                        input logic [W-1:0] a, b, lo, hi, input bit poke);
    logic [W-1:0]  elo, ehi;
    logic [3:0]    enz;
    logic [NI-1:0] seen;
    int            c;
    model(m, s, a, b, lo, hi, elo, ehi, enz);
    @(negedge clk);
    mode = m; sat_en = s; in1 = a; in2 = b; acc_lo = lo; acc_hi = hi;
    start_v = '1;
    @(negedge clk);
    start_v = '0;
    c = 1;
    seen = '0;
    for (int i = 0; i < NI; i++) chk($sformatf("%s busy[%0d]", tag, i), 64'(busy_v[i]), 64'(1));
    scramble();
    if (poke) start_v = '1;
    while (seen != '1 && c < 30) begin
      @(negedge clk);
      c++;
      start_v = '0;
      for (int i = 0; i < NI; i++) begin
        if (!seen[i] && done_v[i]) begin
          seen[i] = 1'b1;
          chk($sformatf("%s lat[%0d]", tag, i), 64'(c), 64'(lat_of(i)));
          chk($sformatf("%s busy_end[%0d]", tag, i), 64'(busy_v[i]), 64'(0));
          chk($sformatf("%s lo[%0d]", tag, i), 64'(rlo[i]), 64'(elo));
          chk($sformatf("%s hi[%0d]", tag, i), 64'(rhi[i]), 64'(ehi));
          chk($sformatf("%s nzcv[%0d]", tag, i), 64'(nz[i]), 64'(enz));
        end
      end
    end
    for (int i = 0; i < NI; i++)
      if (!seen[i]) chk($sformatf("%s timeout[%0d]", tag, i), 64'(0), 64'(1));
    @(negedge clk);
    chk($sformatf("%s done_pulse", tag), 64'(done_v), 64'(0));
    for (int i = 0; i < NI; i++) chk($sformatf("%s hold[%0d]", tag, i), 64'(rlo[i]), 64'(elo));
  endtask

  task automatic reset_abort();
    logic any_done;
    @(negedge clk);
    mode = MODE_MUL; sat_en = 1'b0; in1 = 32'h1234_5678; in2 = 32'h0; acc_lo = '0; acc_hi = '0;
    start_v = '1;
    @(negedge clk);
    start_v = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("abort busy[%0d]", i), 64'(busy_v[i]), 64'(0));
      chk($sformatf("abort done[%0d]", i), 64'(done_v[i]), 64'(0));
      chk($sformatf("abort lo[%0d]", i), 64'(rlo[i]), 64'(0));
      chk($sformatf("abort hi[%0d]", i), 64'(rhi[i]), 64'(0));
      chk($sformatf("abort nzcv[%0d]", i), 64'(nz[i]), 64'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    any_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_v != '0) any_done = 1'b1;
    end
    chk("abort no_done", 64'(any_done), 64'(0));
  endtask

  // Second start lands in the done cycle of the first operation
  task automatic back_to_back(input int i);
    logic [2:0]   m1, m2;
    logic         s1, s2;
    logic [W-1:0] a1, b1, l1, h1, a2, b2, l2, h2;
    logic [W-1:0] elo, ehi;
    logic [3:0]   enz;
    int           c;
    m1 = 3'($urandom); s1 = 1'($urandom);
    a1 = rand_word(); b1 = rand_word(); l1 = rand_word(); h1 = rand_word();
    m2 = 3'($urandom); s2 = 1'($urandom);
    a2 = rand_word(); b2 = rand_word(); l2 = rand_word(); h2 = rand_word();
    @(negedge clk);
    mode = m1; sat_en = s1; in1 = a1; in2 = b1; acc_lo = l1; acc_hi = h1;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    c = 1;
    while (!done_v[i] && c < 30) begin
      @(negedge clk);
      c++;
    end
    model(m1, s1, a1, b1, l1, h1, elo, ehi, enz);
    chk($sformatf("b2b first_lo[%0d]", i), 64'(rlo[i]), 64'(elo));
    mode = m2; sat_en = s2; in1 = a2; in2 = b2; acc_lo = l2; acc_hi = h2;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    c = 1;
    while (!done_v[i] && c < 30) begin
      @(negedge clk);
      c++;
    end
    model(m2, s2, a2, b2, l2, h2, elo, ehi, enz);
    chk($sformatf("b2b lat[%0d]", i), 64'(c), 64'(lat_of(i)));
    chk($sformatf("b2b lo[%0d]", i), 64'(rlo[i]), 64'(elo));
    chk($sformatf("b2b hi[%0d]", i), 64'(rhi[i]), 64'(ehi));
    chk($sformatf("b2b nzcv[%0d]", i), 64'(nz[i]), 64'(enz));
  endtask

  initial begin
    reset = 1'b1;
    start_v = '0;
    mode = '0; sat_en = 1'b0; in1 = '0; in2 = '0; acc_lo = '0; acc_hi = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset busy[%0d]", i), 64'(busy_v[i]), 64'(0));
      chk($sformatf("reset done[%0d]", i), 64'(done_v[i]), 64'(0));
      chk($sformatf("reset lo[%0d]", i), 64'(rlo[i]), 64'(0));
      chk($sformatf("reset nzcv[%0d]", i), 64'(nz[i]), 64'(0));
    end
    reset = 1'b0;

    run_op("umull_max", MODE_UMULL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    run_op("smlal_zero", MODE_SMLAL, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'h0000_000F, 32'h0, 1'b0);
    run_op("mla_sat", MODE_MLA, 1'b1, 32'h4000_0000, 32'd2, 32'h0, 32'h0, 1'b0);
    run_op("mla_nosat", MODE_MLA, 1'b0, 32'h4000_0000, 32'd2, 32'h0, 32'h0, 1'b0);
    run_op("smull_poke", MODE_SMULL, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0, 1'b1);
    reset_abort();
    run_op("mul_7x6", MODE_MUL, 1'b0, 32'd7, 32'd6, 32'h0, 32'h0, 1'b0);

    for (int n = 0; n < 60; n++)
      run_op($sformatf("rand%0d", n), 3'($urandom), 1'($urandom),
             rand_word(), rand_word(), rand_word(), rand_word(), 1'($urandom));

    for (int i = 0; i < NI; i++) begin
      back_to_back(i);
      back_to_back(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
